xcorr_peak_finder: RTL and testbench

//  Sits directly downstream of the cross-correlation stage. Consumes its six 23-lag xcorr vectors on each validIn strobe.

---
 rtl/xcorr_pkg.sv | 23 ++
 rtl/xcorr_peak_finder_if.sv | 34 +++
 rtl/xcorr_peak_finder_argmax_tracker.sv | 29 ++
 rtl/xcorr_peak_finder.sv | 123 ++++++++++++
 tb/tb_xcorr_peak_finder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xcorr_pkg.sv
// Shared constants, types and FSM encoding for the cross-correlation peak finder.
// Lag index k in a vector maps to a sample delay of k - MAX_SAMPLES_DELAY.
package xcorr_pkg;

  localparam int NUM_BITS_XCORR    = 32;
  localparam int MAX_SAMPLES_DELAY = 11;
  localparam int NUM_LAGS          = 2 * MAX_SAMPLES_DELAY + 1;
  localparam int NUM_XCORRS        = 6;
  localparam int LAG_W             = $clog2(MAX_SAMPLES_DELAY + 1) + 1;
  localparam int IDX_W             = $clog2(NUM_LAGS);

  typedef logic signed [NUM_BITS_XCORR-1:0] xcorr_t;
  typedef xcorr_t [NUM_LAGS-1:0]            xcorr_vec_t;
  typedef logic signed [LAG_W-1:0]          lag_t;
  typedef logic [IDX_W-1:0]                 idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/xcorr_peak_finder_if.sv
// Frame handshake between the xcorr stage, the peak finder and the DOA stage.
// Six discrete vector/result signals stand in for a 2D array.
interface xcorr_peak_finder_if;
  import xcorr_pkg::*;

  logic       validIn;
  xcorr_vec_t xCorrIn0, xCorrIn1, xCorrIn2, xCorrIn3, xCorrIn4, xCorrIn5;
  logic       validOut;
  lag_t       lag0, lag1, lag2, lag3, lag4, lag5;
  xcorr_t     peak0, peak1, peak2, peak3, peak4, peak5;
  logic       busy;
  logic       overrun;

  modport master (
    output validIn,
    output xCorrIn0, xCorrIn1, xCorrIn2, xCorrIn3, xCorrIn4, xCorrIn5,
    input  validOut,
    input  lag0, lag1, lag2, lag3, lag4, lag5,
    input  peak0, peak1, peak2, peak3, peak4, peak5,
    input  busy,
    input  overrun
  );

  modport slave (
    input  validIn,
    input  xCorrIn0, xCorrIn1, xCorrIn2, xCorrIn3, xCorrIn4, xCorrIn5,
    output validOut,
    output lag0, lag1, lag2, lag3, lag4, lag5,
    output peak0, peak1, peak2, peak3, peak4, peak5,
    output busy,
    output overrun
  );

endinterface

// File: rtl/xcorr_peak_finder_argmax_tracker.sv
// Running maximum of one pair's xcorr vector; strict greater-than keeps the
// earliest (most negative lag) index on ties.
module argmax_tracker
  import xcorr_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   update,
  input  xcorr_t cand_val,
  input  idx_t   cand_idx,
  output xcorr_t best_val,
  output idx_t   best_idx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (load) begin
      best_val <= cand_val;
      best_idx <= cand_idx;
    end else if (update && (cand_val > best_val)) begin
      best_val <= cand_val;
      best_idx <= cand_idx;
    end
  end

endmodule

// File: rtl/xcorr_peak_finder.sv
// Per-pair argmax over the 23 xcorr lags, one lag per cycle, six pairs in parallel.
// Emits signed sample delays and peak values once per accepted frame.
module xcorr_peak_finder
  import xcorr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  xcorr_peak_finder_if.slave bus
);

  localparam idx_t LAST_IDX = idx_t'(NUM_LAGS - 1);

  function automatic lag_t to_lag(input idx_t idx);
    logic signed [IDX_W:0] wide;
    wide = $signed({1'b0, idx}) - $signed((IDX_W + 1)'(MAX_SAMPLES_DELAY));
    return lag_t'(wide);
  endfunction

  xcorr_vec_t xin      [NUM_XCORRS];
  xcorr_vec_t snap     [NUM_XCORRS];
  xcorr_t     best_val [NUM_XCORRS];
  idx_t       best_idx [NUM_XCORRS];
  lag_t       lag_r    [NUM_XCORRS];
  xcorr_t     peak_r   [NUM_XCORRS];

  state_t state;
  idx_t   k;
  logic   valid_out_r;
  logic   overrun_r;
  logic   load;
  logic   update;

  assign xin[0] = bus.xCorrIn0;
  assign xin[1] = bus.xCorrIn1;
  assign xin[2] = bus.xCorrIn2;
  assign xin[3] = bus.xCorrIn3;
  assign xin[4] = bus.xCorrIn4;
  assign xin[5] = bus.xCorrIn5;

  assign load   = (state == IDLE) && bus.validIn;
  assign update = (state == SCAN);

  // Lag 0 seeds the tracker straight from the input port on the accept edge;
  // later lags come from the snapshot so upstream is free to move on.
  for (genvar p = 0; p < NUM_XCORRS; p++) begin : g_pair
    xcorr_t cand_val;
    idx_t   cand_idx;

    assign cand_val = load ? xcorr_t'(xin[p][0]) : xcorr_t'(snap[p][k]);
    assign cand_idx = load ? '0 : k;

    argmax_tracker u_trk (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .update   (update),
      .cand_val (cand_val),
      .cand_idx (cand_idx),
      .best_val (best_val[p]),
      .best_idx (best_idx[p])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      valid_out_r <= 1'b0;
      overrun_r   <= 1'b0;
      for (int p = 0; p < NUM_XCORRS; p++) begin
        snap[p]   <= '0;
        lag_r[p]  <= '0;
        peak_r[p] <= '0;
      end
    end else begin
      valid_out_r <= 1'b0;
      if (bus.validIn && (state != IDLE)) overrun_r <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.validIn) begin
            for (int p = 0; p < NUM_XCORRS; p++) snap[p] <= xin[p];
            k     <= idx_t'(1);
            state <= SCAN;
          end
        end
        SCAN: begin
          if (k == LAST_IDX) begin
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + idx_t'(1);
          end
        end
        DONE: begin
          for (int p = 0; p < NUM_XCORRS; p++) begin
            lag_r[p]  <= to_lag(best_idx[p]);
            peak_r[p] <= best_val[p];
          end
          valid_out_r <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.validOut = valid_out_r;
  assign bus.busy     = (state != IDLE);
  assign bus.overrun  = overrun_r;
  assign bus.lag0     = lag_r[0];
  assign bus.lag1     = lag_r[1];
  assign bus.lag2     = lag_r[2];
  assign bus.lag3     = lag_r[3];
  assign bus.lag4     = lag_r[4];
  assign bus.lag5     = lag_r[5];
  assign bus.peak0    = peak_r[0];
  assign bus.peak1    = peak_r[1];
  assign bus.peak2    = peak_r[2];
  assign bus.peak3    = peak_r[3];
  assign bus.peak4    = peak_r[4];
  assign bus.peak5    = peak_r[5];

endmodule

// File: tb/tb_xcorr_peak_finder.sv
// Bench for xcorr_peak_finder: directed frames from the block description plus
// randomized frames checked against a plain argmax model.
module tb_xcorr_peak_finder;
  import xcorr_pkg::*;

  localparam int LATENCY = NUM_LAGS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  xcorr_t cur [NUM_XCORRS][NUM_LAGS];
  int     exp_lag  [NUM_XCORRS];
  int     exp_peak [NUM_XCORRS];

  xcorr_peak_finder_if bus ();

  xcorr_peak_finder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic xcorr_vec_t pack_pair(input int p);
    xcorr_vec_t v;
    for (int k = 0; k < NUM_LAGS; k++) v[k] = cur[p][k];
    return v;
  endfunction

  task automatic drive_cur();
    bus.xCorrIn0 = pack_pair(0);
    bus.xCorrIn1 = pack_pair(1);
    bus.xCorrIn2 = pack_pair(2);
    bus.xCorrIn3 = pack_pair(3);
    bus.xCorrIn4 = pack_pair(4);
    bus.xCorrIn5 = pack_pair(5);
  endtask

  function automatic int obs_lag(input int p);
    case (p)
      0: return int'(bus.lag0);
      1: return int'(bus.lag1);
      2: return int'(bus.lag2);
      3: return int'(bus.lag3);
      4: return int'(bus.lag4);
      default: return int'(bus.lag5);
    endcase
  endfunction

  function automatic int obs_peak(input int p);
    case (p)
      0: return int'(bus.peak0);
      1: return int'(bus.peak1);
      2: return int'(bus.peak2);
      3: return int'(bus.peak3);
      4: return int'(bus.peak4);
      default: return int'(bus.peak5);
    endcase
  endfunction

  // Reference: first strict maximum of each vector, lag = index - MAX_SAMPLES_DELAY.
  task automatic model();
    for (int p = 0; p < NUM_XCORRS; p++) begin
      longint bv = longint'(cur[p][0]);
      int     bi = 0;
      for (int k = 1; k < NUM_LAGS; k++)
        if (longint'(cur[p][k]) > bv) begin
          bv = longint'(cur[p][k]);
          bi = k;
        end
      exp_lag[p]  = bi - MAX_SAMPLES_DELAY;
      exp_peak[p] = int'(bv);
    end
  endtask

  task automatic fill_const(input int p, input xcorr_t val);
    for (int k = 0; k < NUM_LAGS; k++) cur[p][k] = val;
  endtask

  task automatic fill_random(input int mode);
    for (int p = 0; p < NUM_XCORRS; p++)
      for (int k = 0; k < NUM_LAGS; k++)
        if (mode == 0) cur[p][k] = xcorr_t'($urandom);
        else           cur[p][k] = xcorr_t'(int'($urandom_range(0, 3)) - 2);
  endtask

  // Drive the current frame and strobe validIn for one edge; returns just after that edge.
  task automatic pulse_frame();
    @(negedge clk);
    drive_cur();
    bus.validIn = 1'b1;
    @(negedge clk);
    bus.validIn = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.validOut && lat < 60);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.validOut !== 1'b0) $display("FAIL reset_validOut got=%0b exp=0", bus.validOut); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", bus.busy); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); else passed++;
    for (int p = 0; p < NUM_XCORRS; p++) begin
      total++; if (obs_lag(p) !== 0) $display("FAIL reset_lag%0d got=%0d exp=0", p, obs_lag(p)); else passed++;
      total++; if (obs_peak(p) !== 0) $display("FAIL reset_peak%0d got=%0d exp=0", p, obs_peak(p)); else passed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single_peak();
    int lat;
    for (int p = 0; p < NUM_XCORRS; p++) fill_const(p, '0);
    cur[0][15] = 1000;
    for (int p = 1; p < NUM_XCORRS; p++) cur[p][11] = 7;
    pulse_frame();
    total++; if (bus.busy !== 1'b1) $display("FAIL single_busy got=%0b exp=1", bus.busy); else passed++;
    wait_valid(lat);
    total++; if (lat !== LATENCY) $display("FAIL single_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    total++; if (obs_lag(0) !== 4) $display("FAIL single_lag0 got=%0d exp=4", obs_lag(0)); else passed++;
    total++; if (obs_peak(0) !== 1000) $display("FAIL single_peak0 got=%0d exp=1000", obs_peak(0)); else passed++;
    for (int p = 1; p < NUM_XCORRS; p++) begin
      total++; if (obs_lag(p) !== 0) $display("FAIL single_lag%0d got=%0d exp=0", p, obs_lag(p)); else passed++;
      total++; if (obs_peak(p) !== 7) $display("FAIL single_peak%0d got=%0d exp=7", p, obs_peak(p)); else passed++;
    end
    @(negedge clk);
    total++; if (bus.validOut !== 1'b0) $display("FAIL single_pulse_width got=%0b exp=0", bus.validOut); else passed++;
    total++; if (obs_lag(0) !== 4) $display("FAIL single_hold_lag0 got=%0d exp=4", obs_lag(0)); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy got=%0b exp=0", bus.busy); else passed++;
  endtask

  task automatic test_tie();
    int lat;
    for (int p = 0; p < NUM_XCORRS; p++) fill_const(p, '0);
    cur[2][3]  = 500;
    cur[2][20] = 500;
    pulse_frame();
    wait_valid(lat);
    total++; if (lat !== LATENCY) $display("FAIL tie_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    total++; if (obs_lag(2) !== -8) $display("FAIL tie_lag2 got=%0d exp=-8", obs_lag(2)); else passed++;
    total++; if (obs_peak(2) !== 500) $display("FAIL tie_peak2 got=%0d exp=500", obs_peak(2)); else passed++;
    total++; if (obs_lag(0) !== -11) $display("FAIL tie_allzero_lag0 got=%0d exp=-11", obs_lag(0)); else passed++;
  endtask

  task automatic test_extremes();
    int lat;
    for (int p = 0; p < NUM_XCORRS; p++) fill_const(p, '0);
    fill_const(3, -100);
    cur[3][22] = -5;
    fill_const(4, xcorr_t'(32'h8000_0000));
    cur[4][0] = xcorr_t'(32'h8000_0001);
    fill_const(5, xcorr_t'(32'h8000_0000));
    cur[5][12] = xcorr_t'(32'h7FFF_FFFF);
    pulse_frame();
    wait_valid(lat);
    total++; if (lat !== LATENCY) $display("FAIL ext_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    total++; if (obs_lag(3) !== 11) $display("FAIL ext_lag3 got=%0d exp=11", obs_lag(3)); else passed++;
    total++; if (obs_peak(3) !== -5) $display("FAIL ext_peak3 got=%0d exp=-5", obs_peak(3)); else passed++;
    total++; if (obs_lag(4) !== -11) $display("FAIL ext_lag4 got=%0d exp=-11", obs_lag(4)); else passed++;
    total++; if (obs_peak(4) !== -2147483647) $display("FAIL ext_peak4 got=%0d exp=-2147483647", obs_peak(4)); else passed++;
    total++; if (obs_lag(5) !== 1) $display("FAIL ext_lag5 got=%0d exp=1", obs_lag(5)); else passed++;
    total++; if (obs_peak(5) !== 2147483647) $display("FAIL ext_peak5 got=%0d exp=2147483647", obs_peak(5)); else passed++;
  endtask

  // Frames issued back to back; inputs are scrambled right after each accept.
  task automatic test_back_to_back();
    int lat;
    for (int f = 0; f < 10; f++) begin
      fill_random(f % 2);
      model();
      pulse_frame();
      fill_random(0);
      drive_cur();
      wait_valid(lat);
      total++; if (lat !== LATENCY) $display("FAIL b2b%0d_latency got=%0d exp=%0d", f, lat, LATENCY); else passed++;
      for (int p = 0; p < NUM_XCORRS; p++) begin
        total++; if (obs_lag(p) !== exp_lag[p]) $display("FAIL b2b%0d_lag%0d got=%0d exp=%0d", f, p, obs_lag(p), exp_lag[p]); else passed++;
        total++; if (obs_peak(p) !== exp_peak[p]) $display("FAIL b2b%0d_peak%0d got=%0d exp=%0d", f, p, obs_peak(p), exp_peak[p]); else passed++;
      end
    end
    total++; if (bus.overrun !== 1'b0) $display("FAIL b2b_overrun got=%0b exp=0", bus.overrun); else passed++;
  endtask

  task automatic test_overrun();
    int lat;
    int pulses;
    fill_random(0);
    model();
    pulse_frame();
    fill_random(0);
    drive_cur();
    lat = 0;
    pulses = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.validOut) pulses++;
      bus.validIn = (lat == 5);
    end while (!bus.validOut && lat < 60);
    bus.validIn = 1'b0;
    total++; if (lat !== LATENCY) $display("FAIL ovr_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_flag got=%0b exp=1", bus.overrun); else passed++;
    for (int p = 0; p < NUM_XCORRS; p++) begin
      total++; if (obs_lag(p) !== exp_lag[p]) $display("FAIL ovr_lag%0d got=%0d exp=%0d", p, obs_lag(p), exp_lag[p]); else passed++;
      total++; if (obs_peak(p) !== exp_peak[p]) $display("FAIL ovr_peak%0d got=%0d exp=%0d", p, obs_peak(p), exp_peak[p]); else passed++;
    end
    repeat (30) begin
      @(negedge clk);
      if (bus.validOut) pulses++;
    end
    total++; if (pulses !== 1) $display("FAIL ovr_validOut_count got=%0d exp=1", pulses); else passed++;
    fill_random(1);
    model();
    pulse_frame();
    wait_valid(lat);
    total++; if (lat !== LATENCY) $display("FAIL ovr_next_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    total++; if (obs_lag(1) !== exp_lag[1]) $display("FAIL ovr_next_lag1 got=%0d exp=%0d", obs_lag(1), exp_lag[1]); else passed++;
    total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky got=%0b exp=1", bus.overrun); else passed++;
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    int pulses;
    fill_random(0);
    pulse_frame();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy got=%0b exp=0", bus.busy); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL mid_rst_overrun got=%0b exp=0", bus.overrun); else passed++;
    total++; if (obs_peak(0) !== 0) $display("FAIL mid_rst_peak0 got=%0d exp=0", obs_peak(0)); else passed++;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.validOut) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL mid_rst_validOut_count got=%0d exp=0", pulses); else passed++;
    fill_random(0);
    model();
    pulse_frame();
    wait_valid(lat);
    total++; if (lat !== LATENCY) $display("FAIL mid_rst_next_latency got=%0d exp=%0d", lat, LATENCY); else passed++;
    for (int p = 0; p < NUM_XCORRS; p++) begin
      total++; if (obs_lag(p) !== exp_lag[p]) $display("FAIL mid_rst_lag%0d got=%0d exp=%0d", p, obs_lag(p), exp_lag[p]); else passed++;
      total++; if (obs_peak(p) !== exp_peak[p]) $display("FAIL mid_rst_peak%0d got=%0d exp=%0d", p, obs_peak(p), exp_peak[p]); else passed++;
    end
  endtask

  task automatic test_reset_with_valid();
    fill_random(0);
    @(negedge clk);
    drive_cur();
    bus.validIn = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.validIn = 1'b0;
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_valid_busy got=%0b exp=0", bus.busy); else passed++;
  endtask

  initial begin
    bus.validIn = 1'b0;
    for (int p = 0; p < NUM_XCORRS; p++) fill_const(p, '0);
    drive_cur();
    test_reset();
    test_single_peak();
    test_tie();
    test_extremes();
    test_back_to_back();
    test_overrun();
    test_reset_mid_scan();
    test_reset_with_valid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
